// File: rtl/cpu_pkg.sv
// Shared pipeline types for the MEM stage.
// State encoding and data-memory geometry.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int DWORD_BYTES = 8;

  function automatic logic [63:0] dword_align(
    input logic [63:0] a
  );
    return {a[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering between the 64-bit memory port and the core.
// Load: lane extract + zero-extend. Store: replicate + enables.
module byte_lane_align
  import cpu_pkg::*;
(
  input  logic                   byte_sel,
  input  logic [2:0]             lane,
  input  logic [63:0]            rdata,
  input  logic [63:0]            wdata_in,
  output logic [63:0]            ld_data,
  output logic [63:0]            wdata,
  output logic [DWORD_BYTES-1:0] byte_en
);

  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = rdata[{lane, 3'b000} +: 8];
    if (byte_sel) begin
      ld_data = {56'd0, rd_byte};
      wdata   = {DWORD_BYTES{wdata_in[7:0]}};
      byte_en = DWORD_BYTES'(1) << lane;
    end else begin
      ld_data = rdata;
      wdata   = wdata_in;
      byte_en = '1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: turns load/store controls into a req/ack memory
// transaction, stalling the front end until it completes.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        MemToReg_MEM,
  input  logic        RegWrite_MEM,
  input  logic        xferByte_MEM,
  input  logic [63:0] ALUResult_MEM,
  input  logic [63:0] storeData_MEM,
  input  logic [4:0]  Rd_MEM,
  input  logic [63:0] memRdata,
  input  logic        memAck,
  output logic        memReq,
  output logic        memWe,
  output logic [63:0] memAddr,
  output logic [63:0] memWdata,
  output logic [7:0]  memByteEn,
  output logic        stall_MEM,
  output logic [63:0] dataFromMem_MEM,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [4:0]  Rd_out,
  output logic [63:0] ALUResult_out,
  output logic        memError
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_e  state;
  logic [CW-1:0] cnt;
  logic [63:0] data_q;
  logic        err_q;

  logic        mem_op;
  logic        misaligned;
  logic        in_req;
  logic        expired;
  logic [63:0] ld_data;
  logic [63:0] wdata;
  logic [7:0]  be;

  byte_lane_align u_align (
    .byte_sel (xferByte_MEM),
    .lane     (ALUResult_MEM[2:0]),
    .rdata    (memRdata),
    .wdata_in (storeData_MEM),
    .ld_data  (ld_data),
    .wdata    (wdata),
    .byte_en  (be)
  );

  assign mem_op     = MemRead_MEM | MemWrite_MEM;
  assign misaligned = ~xferByte_MEM & (|ALUResult_MEM[2:0]);
  assign in_req     = (state == REQ);
  assign expired    = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (mem_op && misaligned) begin
            err_q  <= 1'b1;
            data_q <= '0;
            state  <= DONE;
          end else if (mem_op) begin
            state <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // ack beats a timeout landing in the same cycle
          if (memAck) begin
            data_q <= MemRead_MEM ? ld_data : '0;
            state  <= DONE;
          end else if (expired) begin
            err_q  <= 1'b1;
            data_q <= '0;
            state  <= DONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign memReq    = in_req;
  assign memWe     = in_req & MemWrite_MEM;
  assign memByteEn = in_req ? be : 8'd0;
  assign memAddr   = dword_align(ALUResult_MEM);
  assign memWdata  = wdata;
  assign memError  = err_q;

  assign stall_MEM = reset & mem_op & (state != DONE);

  assign dataFromMem_MEM = (state == DONE) ? data_q : 64'd0;

  assign RegWrite_out  = RegWrite_MEM & ~stall_MEM;
  assign MemToReg_out  = MemToReg_MEM;
  assign Rd_out        = Rd_MEM;
  assign ALUResult_out = ALUResult_MEM;

endmodule
